data_mem_arbiter: RTL
=====================

// Module: data_mem_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer for the 512x32 data memory: shares its single addr/writeData
//  port between the CPU load/store path and the debug peek/poke path. Sequences each write as a
//  two-cycle issue/commit so memory sees addr/data stable when it commits; reads are single-cycle.
//  Sits between the CPU datapath, debug front end, and data memory.
// PARAMETERS
//  DEPTH       512  number of valid 32-bit words; word addresses >= DEPTH are rejected
//  DBG_FIRST   0    1: debug always wins a tie; 0: round-robin on tie
// PORTS
//  Clk        in   1   clock, all state on rising edge
//  Rst        in   1   asynchronous active-low reset
//  cpu_req    in   1   CPU request; held high with cmd stable until cpu_ack
//  cpu_we     in   1   1 = write, 0 = read
//  cpu_addr   in   32  CPU word address
//  cpu_wdata  in   32  CPU write data
//  cpu_ack    out  1   one-cycle pulse: request complete
//  cpu_rdata  out  32  read data, valid with cpu_ack, held until next CPU ack
//  cpu_err    out  1   with cpu_ack: address out of range, op dropped
//  dbg_req/dbg_we/dbg_addr/dbg_wdata/dbg_ack/dbg_rdata/dbg_err: same as cpu_* for debug port
//  mem_addr   out  32  to memory addr
//  mem_wdata  out  32  to memory writeData
//  mem_read   out  1   to memory memRead
//  mem_write  out  1   to memory memWrite
//  mem_wen    out  1   to memory writeEnable
//  mem_rdata  in   32  from memory readData (combinational on mem_addr/mem_read)
//  busy       out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_last=CPU; all outputs 0 (acks, errs, rdata regs, mem_* , busy).
//  States: IDLE, RD, WR_ISSUE, WR_COMMIT, ERR.
//  IDLE: if no req, stay, mem_* = 0. Else select winner: one req -> it; both -> DBG if DBG_FIRST,
//   else the port not in rr_last. Latch winner id, we, addr, wdata into owner regs; rr_last<=winner.
//   addr >= DEPTH -> ERR; we=0 -> RD; we=1 -> WR_ISSUE.
//  RD (1 cycle): mem_addr=owner addr, mem_read=1; capture mem_rdata into owner rdata reg,
//   pulse owner ack -> IDLE. Read latency: req seen in IDLE to ack = 2 cycles.
//  WR_ISSUE (1 cycle): mem_addr/mem_wdata=owner regs, mem_write=1, mem_wen=1 -> WR_COMMIT.
//  WR_COMMIT (1 cycle): mem_addr/mem_wdata held, mem_write=mem_wen=0 (memory commits now);
//   pulse owner ack -> IDLE. Write latency = 3 cycles.
//  ERR (1 cycle): no mem_* activity; pulse owner ack and err; owner rdata <= 0 -> IDLE.
//  Acks are exactly one cycle; a requester sampling ack must drop or change req next cycle;
//   req still high in IDLE after ack is a new request.
//  Loser of a tie keeps req asserted and is granted on the very next IDLE (no starvation in RR mode).
//  Owner cmd is latched in IDLE; requester input changes mid-op are ignored.
//  Non-owner rdata reg is never modified.
//  Address compare uses full 32 bits (no truncation/wrap); mem_addr passes the full 32-bit value.
//  Async reset mid-op: immediately IDLE, outputs 0; a write reset in WR_ISSUE may be lost — defined.
// TESTING
//  1 Reset: Rst=0 mid-WR_ISSUE -> all outputs 0 same cycle, state IDLE, busy=0.
//  2 CPU read addr 5 (mem holds 5) -> mem_read=1 one cycle later, cpu_ack+cpu_rdata=5 at cycle 2.
//  3 CPU write addr 10 data 32'hDEADBEEF -> mem_write/mem_wen 1 cycle, addr/data held next cycle,
//    cpu_ack at cycle 3; subsequent read of 10 returns DEADBEEF.
//  4 Both req same cycle, DBG_FIRST=0, rr_last=CPU -> DBG served first, CPU ack after; repeat
//    with both held -> grants alternate CPU,DBG,CPU.
//  5 dbg read addr 512 -> dbg_ack+dbg_err=1, dbg_rdata=0, no mem_read/mem_write pulse.
//  6 CPU write in progress, dbg_req rises in WR_ISSUE -> dbg waits, granted in IDLE after cpu_ack.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Requester-side handshake bundle for the data memory arbiter (one instance per requester).
interface data_mem_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata, err
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Arbitrates the CPU and debug requesters onto the single data memory port; reads take one
// memory cycle, writes are sequenced as issue + commit so addr/data stay stable at commit.
module data_mem_arbiter #(
  parameter int unsigned DEPTH     = 512,
  parameter bit          DBG_FIRST = 1'b0
) (
  input  logic                Clk,
  input  logic                Rst,
  data_mem_arbiter_if.slave   cpu,
  data_mem_arbiter_if.slave   dbg,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_wen,
  input  logic [31:0]         mem_rdata,
  output logic                busy
);

  typedef enum logic [2:0] {StIdle, StRd, StWrIssue, StWrCommit, StErr} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;      // 1 = debug owns the current op
  logic        rr_last_q, rr_last_d;  // 1 = debug won last
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        cpu_ack_q, cpu_ack_d, cpu_err_q, cpu_err_d;
  logic        dbg_ack_q, dbg_ack_d, dbg_err_q, dbg_err_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;

  // During a port's ack cycle its req is stale (requester reacts next cycle), so ignore it.
  logic cpu_req_eff, dbg_req_eff, grant_dbg;
  logic [31:0] sel_addr;

  assign cpu_req_eff = cpu.req & ~cpu_ack_q;
  assign dbg_req_eff = dbg.req & ~dbg_ack_q;
  assign grant_dbg   = dbg_req_eff & (~cpu_req_eff | DBG_FIRST | ~rr_last_q);
  assign sel_addr    = grant_dbg ? dbg.addr : cpu.addr;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_ack_d   = 1'b0;
    cpu_err_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    dbg_err_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wen     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cpu_req_eff || dbg_req_eff) begin
          owner_d   = grant_dbg;
          rr_last_d = grant_dbg;
          we_d      = grant_dbg ? dbg.we : cpu.we;
          addr_d    = sel_addr;
          wdata_d   = grant_dbg ? dbg.wdata : cpu.wdata;
          if (sel_addr >= DEPTH) begin
            state_d = StErr;
          end else if (grant_dbg ? dbg.we : cpu.we) begin
            state_d = StWrIssue;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        mem_addr = addr_q;
        mem_read = 1'b1;
        if (owner_q) begin
          dbg_rdata_d = mem_rdata;
          dbg_ack_d   = 1'b1;
        end else begin
          cpu_rdata_d = mem_rdata;
          cpu_ack_d   = 1'b1;
        end
        state_d = StIdle;
      end
      StWrIssue: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_write = 1'b1;
        mem_wen   = 1'b1;
        state_d   = StWrCommit;
      end
      StWrCommit: begin
        // Strobes drop while addr/data stay put; memory commits on this edge.
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (owner_q) dbg_ack_d = 1'b1;
        else         cpu_ack_d = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        if (owner_q) begin
          dbg_ack_d   = 1'b1;
          dbg_err_d   = 1'b1;
          dbg_rdata_d = 32'h0;
        end else begin
          cpu_ack_d   = 1'b1;
          cpu_err_d   = 1'b1;
          cpu_rdata_d = 32'h0;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      rr_last_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      cpu_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      dbg_err_q   <= 1'b0;
      cpu_rdata_q <= 32'h0;
      dbg_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_err_q   <= cpu_err_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_err_q   <= dbg_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign cpu.ack   = cpu_ack_q;
  assign cpu.err   = cpu_err_q;
  assign cpu.rdata = cpu_rdata_q;
  assign dbg.ack   = dbg_ack_q;
  assign dbg.err   = dbg_err_q;
  assign dbg.rdata = dbg_rdata_q;

endmodule
